// File: rtl/sdram_rw_arbiter.sv
// Arbitrates the SDRAM command engine between refresh, camera write bursts and VGA read bursts.
// Latency: a request is decided in a one-cycle ARB slot, and the *_start pulse follows on the next cycle (done -> ARB -> start).
// Backpressure: requests are levels held until granted; the active burst is never preempted, it ends only on its own *_done.
// Ports: clk/rst_n; init_end; ref_req/wr_req/rd_req (levels); ref_done/wr_done/rd_done (pulses);
//        ref_start/wr_start/rd_start (pulses); wr_addr/rd_addr (burst start addresses); busy; frame_valid; wr_frame_end.
module sdram_rw_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic              ref_req,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              ref_done,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              ref_start,
  output logic              wr_start,
  output logic              rd_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              frame_valid,
  output logic              wr_frame_end
);

  typedef enum logic [2:0] {S_INIT, S_ARB, S_REF, S_WRITE, S_READ} state_t;

  localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] FRAME = (ADDR_W+1)'(FRAME_WORDS);

  state_t state, state_nxt;
  logic   entered;      // high during the first cycle of REF/WRITE/READ
  logic   rr_last_rd;   // 1: the last serviced burst was a read

  // One extra bit so the wrap compare cannot overflow near the top of the address space.
  logic [ADDR_W:0] wr_sum, rd_sum;
  logic            wr_wrap, rd_wrap, wr_fin, rd_fin;

  assign wr_sum  = {1'b0, wr_addr} + STEP;
  assign rd_sum  = {1'b0, rd_addr} + STEP;
  assign wr_wrap = (wr_sum >= FRAME);
  assign rd_wrap = (rd_sum >= FRAME);
  // Only the done of the active burst type counts; stray pulses fall through.
  assign wr_fin  = (state == S_WRITE) && wr_done;
  assign rd_fin  = (state == S_READ)  && rd_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (init_end) state_nxt = S_ARB;
      S_ARB: begin
        if (ref_req)
          state_nxt = S_REF;
        else if (wr_req && (!rd_req || !frame_valid || rr_last_rd))
          state_nxt = S_WRITE;
        else if (rd_req && frame_valid)
          state_nxt = S_READ;
      end
      S_REF:   if (ref_done) state_nxt = S_ARB;
      S_WRITE: if (wr_done)  state_nxt = S_ARB;
      S_READ:  if (rd_done)  state_nxt = S_ARB;
      default: state_nxt = S_INIT;
    endcase
  end

  // First-cycle flag and round-robin memory, both updated on the ARB decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entered    <= 1'b0;
      rr_last_rd <= 1'b1;
    end else begin
      entered <= (state == S_ARB) && (state_nxt != S_ARB);
      if (state == S_ARB && state_nxt == S_WRITE) rr_last_rd <= 1'b0;
      if (state == S_ARB && state_nxt == S_READ)  rr_last_rd <= 1'b1;
    end
  end

  // Frame address counters; they only move at burst completion so the
  // address stays stable for the whole burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr      <= '0;
      rd_addr      <= '0;
      frame_valid  <= 1'b0;
      wr_frame_end <= 1'b0;
    end else begin
      wr_frame_end <= 1'b0;
      if (wr_fin) begin
        if (wr_wrap) begin
          wr_addr      <= '0;
          wr_frame_end <= 1'b1;
          frame_valid  <= 1'b1;
        end else begin
          wr_addr <= wr_sum[ADDR_W-1:0];
        end
      end
      if (rd_fin) begin
        if (rd_wrap) rd_addr <= '0;
        else         rd_addr <= rd_sum[ADDR_W-1:0];
      end
    end
  end

  // Output logic
  always_comb begin
    ref_start = entered && (state == S_REF);
    wr_start  = entered && (state == S_WRITE);
    rd_start  = entered && (state == S_READ);
    busy      = (state == S_REF) || (state == S_WRITE) || (state == S_READ);
  end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Self-checking bench for sdram_rw_arbiter: directed scenarios plus a randomized phase,
// every cycle compared against a transaction-level model of the grant/address rules.
// Inputs are driven at the falling edge, outputs sampled at the falling edge.
module tb_sdram_rw_arbiter;
  localparam int BL = 256;
  localparam int FW = 307200;
  localparam int AW = 22;
  localparam int NONE = 0, A_REF = 1, A_WR = 2, A_RD = 3;

  logic clk = 1'b0;
  logic rst_n, init_end, ref_req, wr_req, rd_req, ref_done, wr_done, rd_done;
  logic ref_start, wr_start, rd_start, busy, frame_valid, wr_frame_end;
  logic [AW-1:0] wr_addr, rd_addr;

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_ref = 0, n_wr = 0, n_rd = 0, n_fe = 0, n_wrd = 0, n_rdd = 0;
  int t_ref = 0, t_wr = 0, t_rd = 0, t_refdone = 0, t_rddone = 0, t_init = 0;
  int s_cnt = 0, s_tgt = 1;
  bit force_stray_wr = 0;
  int q_kind[$];
  logic [63:0] q_addr[$];

  // Model state: what is being serviced, whether the start cycle is now, addresses, flags.
  bit m_ready, m_first, m_fv, m_fe, m_lastw;
  int m_act, m_wa, m_ra;

  always #5 clk = ~clk;

  sdram_rw_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end),
    .ref_req(ref_req), .wr_req(wr_req), .rd_req(rd_req),
    .ref_done(ref_done), .wr_done(wr_done), .rd_done(rd_done),
    .ref_start(ref_start), .wr_start(wr_start), .rd_start(rd_start),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .busy(busy),
    .frame_valid(frame_valid), .wr_frame_end(wr_frame_end)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_first = 0; m_fv = 0; m_fe = 0; m_lastw = 0;
    m_act = NONE; m_wa = 0; m_ra = 0;
  endtask

  // One clock of the arbitration rules: idle slot decides, active burst waits for its own done.
  task automatic model_step();
    m_first = 0;
    m_fe = 0;
    if (!m_ready) begin
      m_ready = init_end;
    end else begin
      case (m_act)
        NONE: begin
          if (ref_req) begin m_act = A_REF; m_first = 1; end
          else if (wr_req && (!rd_req || !m_fv || !m_lastw)) begin m_act = A_WR; m_first = 1; m_lastw = 1; end
          else if (rd_req && m_fv) begin m_act = A_RD; m_first = 1; m_lastw = 0; end
        end
        A_REF: if (ref_done) m_act = NONE;
        A_WR: if (wr_done) begin
          m_act = NONE;
          if (m_wa + BL >= FW) begin m_wa = 0; m_fe = 1; m_fv = 1; end
          else m_wa = m_wa + BL;
        end
        A_RD: if (rd_done) begin
          m_act = NONE;
          m_ra = (m_ra + BL >= FW) ? 0 : m_ra + BL;
        end
        default: m_act = NONE;
      endcase
    end
  endtask

  task automatic compare_outputs();
    chk("ref_start", ref_start, (m_act == A_REF) && m_first);
    chk("wr_start", wr_start, (m_act == A_WR) && m_first);
    chk("rd_start", rd_start, (m_act == A_RD) && m_first);
    chk("busy", busy, m_act != NONE);
    chk("wr_addr", wr_addr, m_wa);
    chk("rd_addr", rd_addr, m_ra);
    chk("frame_valid", frame_valid, m_fv);
    chk("wr_frame_end", wr_frame_end, m_fe);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    cyc++;
    @(negedge clk);
    compare_outputs();
    if (ref_start) begin n_ref++; t_ref = cyc; end
    if (wr_start) begin n_wr++; t_wr = cyc; q_kind.push_back(1); q_addr.push_back(64'(wr_addr)); end
    if (rd_start) begin n_rd++; t_rd = cyc; q_kind.push_back(2); q_addr.push_back(64'(rd_addr)); end
    if (wr_frame_end) n_fe++;
  endtask

  // One cycle with a sub-controller responder driven from the model's view of the active burst.
  task automatic step_serve(input int lo, input int hi, input bit rnd);
    ref_done = 0; wr_done = 0; rd_done = 0;
    if (rnd) begin
      wr_req = ($urandom_range(0, 3) != 0);
      rd_req = ($urandom_range(0, 3) != 0);
      if (!ref_req && $urandom_range(0, 99) < 4) ref_req = 1;
      if ($urandom_range(0, 49) == 0) begin
        if (m_act == A_WR) rd_done = 1; else wr_done = (m_act != NONE) ? 1'b1 : 1'b0;
        if (m_act == NONE) rd_done = 1;
      end
    end
    if (force_stray_wr) begin wr_done = 1; force_stray_wr = 0; end
    if (m_act != NONE && s_cnt == s_tgt) begin
      case (m_act)
        A_REF: begin ref_done = 1; t_refdone = cyc; end
        A_WR:  begin wr_done = 1; n_wrd++; end
        A_RD:  begin rd_done = 1; n_rdd++; t_rddone = cyc; end
        default: ;
      endcase
    end
    tick();
    ref_done = 0; wr_done = 0; rd_done = 0;
    if (m_first) begin
      s_cnt = 0;
      s_tgt = $urandom_range(lo, hi);
      if (m_act == A_REF) ref_req = 0;
    end else begin
      s_cnt++;
    end
  endtask

  initial begin
    int guard, snap_ref, snap_rd, saved_wa, start_cnt;
    int exp_k[6];
    logic [63:0] exp_a[6];
    exp_k = '{2, 1, 2, 1, 2, 1};
    exp_a = '{64'd0, 64'd0, 64'd256, 64'd256, 64'd512, 64'd512};

    // 1: reset and init
    rst_n = 0; init_end = 0; ref_req = 0; wr_req = 0; rd_req = 0;
    ref_done = 0; wr_done = 0; rd_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ref_start, wr_start, rd_start, busy, frame_valid, wr_frame_end, wr_addr, rd_addr}, 0);
    rst_n = 1;
    wr_req = 1; rd_req = 1;
    repeat (10) tick();
    chk("t1_no_start_before_init", n_ref + n_wr + n_rd, 0);
    init_end = 1; ref_req = 1; t_init = cyc;
    guard = 0;
    while (n_ref == 0 && guard < 20) begin step_serve(20, 20, 0); guard++; end
    chk("t1_init_to_ref_start", t_ref - t_init, 2);

    // 2: refresh wins over write, write follows two cycles after ref_done
    guard = 0;
    while (n_wr == 0 && guard < 100) begin step_serve(20, 20, 0); guard++; end
    chk("t2_wr_after_refdone", t_wr - t_refdone, 2);
    chk("t2_first_wr_addr", q_addr[q_addr.size()-1], 0);

    // 3: one full frame of writes, reads must stay locked out
    guard = 0;
    while (n_wrd < 1200 && guard < 40000) begin
      step_serve(20, 20, 0);
      guard++;
      if (n_wrd == 1199 && wr_done === 1'b0 && m_act == NONE && s_cnt == 21)
        chk("t3_addr_before_wrap", wr_addr, 306944);
    end
    chk("t3_bursts", n_wrd, 1200);
    chk("t3_wrap_addr", wr_addr, 0);
    chk("t3_frame_end_now", wr_frame_end, 1);
    chk("t3_frame_valid", frame_valid, 1);
    chk("t3_frame_end_count", n_fe, 1);
    chk("t3_no_read_before_frame", n_rd, 0);

    // 4: alternation once a frame is valid
    q_kind.delete(); q_addr.delete();
    start_cnt = n_wr + n_rd; guard = 0;
    while (n_wr + n_rd < start_cnt + 6 && guard < 500) begin step_serve(5, 8, 0); guard++; end
    chk("t4_grant_count", q_kind.size(), 6);
    for (int i = 0; i < 6 && i < q_kind.size(); i++) begin
      chk($sformatf("t4_kind%0d", i), q_kind[i], exp_k[i]);
      chk($sformatf("t4_addr%0d", i), q_addr[i], exp_a[i]);
    end

    // 5: refresh raised mid-read waits for rd_done, then beats the pending write
    guard = 0; snap_rd = n_rd;
    while (n_rd == snap_rd && guard < 200) begin step_serve(5, 8, 0); guard++; end
    s_tgt = 20;
    repeat (3) step_serve(20, 20, 0);
    ref_req = 1; snap_ref = n_ref; snap_rd = n_rd; guard = 0;
    while (m_act == A_RD && guard < 100) begin step_serve(20, 20, 0); guard++; end
    chk("t5_no_ref_during_read", n_ref, snap_ref);
    chk("t5_rd_not_reissued", n_rd, snap_rd);
    guard = 0;
    while (n_ref == snap_ref && guard < 20) begin step_serve(6, 6, 0); guard++; end
    chk("t5_ref_after_rddone", t_ref - t_rddone, 2);
    q_kind.delete(); guard = 0;
    while (q_kind.size() == 0 && guard < 50) begin step_serve(6, 6, 0); guard++; end
    chk("t5_write_after_ref", (q_kind.size() > 0) ? q_kind[0] : 0, 1);

    // randomized phase
    for (int i = 0; i < 6000; i++) step_serve(1, 12, 1);

    // 6: stray wr_done during READ, then reset mid-WRITE
    ref_req = 0; wr_req = 0; rd_req = 1; snap_rd = n_rd; guard = 0;
    while (n_rd == snap_rd && guard < 200) begin step_serve(10, 10, 0); guard++; end
    repeat (3) step_serve(10, 10, 0);
    saved_wa = m_wa; snap_rd = n_rd;
    force_stray_wr = 1;
    step_serve(10, 10, 0);
    step_serve(10, 10, 0);
    chk("t6_stray_wr_addr", wr_addr, saved_wa);
    chk("t6_still_busy", busy, 1);
    chk("t6_no_new_read", n_rd, snap_rd);
    wr_req = 1; rd_req = 0; snap_ref = n_wr; guard = 0;
    while (n_wr == snap_ref && guard < 200) begin step_serve(10, 10, 0); guard++; end
    repeat (3) step_serve(10, 10, 0);
    rst_n = 0;
    #1;
    model_reset();
    chk("t6_async_reset_outputs", {ref_start, wr_start, rd_start, busy, frame_valid, wr_frame_end, wr_addr, rd_addr}, 0);
    repeat (2) tick();
    rst_n = 1; init_end = 0;
    repeat (4) tick();
    chk("t6_idle_after_reset", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
